// File: rtl/denorm_16bit_pkg.sv
// Shared widths and the inter-stage payload of the two-stage denormalizer.
package denorm_16bit_pkg;

    localparam int unsigned MANT_W = 16;
    localparam int unsigned LZC_W  = 4;
    localparam int unsigned AMT_W  = 2;

    typedef struct packed {
        logic [MANT_W-1:0] mant;
        logic [AMT_W-1:0]  lzc;
        logic              zero;
        logic              rnd;
    } stage_t;

endpackage

// File: rtl/denorm_shift_stage.sv
// One pipeline register slice that right-shifts its payload by in_amt << SHIFT_LOG2.
// DENORM_ROUND_EN: track the last shifted-out bit; the FINAL stage adds it to the result.
module denorm_shift_stage
    import denorm_16bit_pkg::*;
#(
    parameter int unsigned SHIFT_LOG2 = 0,
    parameter bit          FINAL      = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  stage_t           in_data,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output stage_t           out_data
);

    logic [LZC_W-1:0] sh;
    stage_t           nxt;

    assign sh = LZC_W'(in_amt) << SHIFT_LOG2;

    // Shift; a zero shift keeps the guard bit produced upstream.
    always_comb begin
        nxt      = in_data;
        nxt.mant = in_data.mant >> sh;
`ifdef DENORM_ROUND_EN
        if (sh != '0) begin
            nxt.rnd = in_data.mant[sh - LZC_W'(1)];
        end
        if (FINAL) begin
            nxt.mant = nxt.mant + MANT_W'(nxt.rnd);
        end
`endif
        if (FINAL) begin
            nxt.rnd = 1'b0;
        end
    end

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= nxt;
            end
        end
    end

endmodule

// File: rtl/denorm_16bit.sv
// Restores a normalized 16-bit mantissa by shifting right by its leading-zero count.
// Optional round-half-up on the last shifted-out bit when DENORM_ROUND_EN is defined.
module denorm_16bit
    import denorm_16bit_pkg::*;
#(
    parameter bit ERR_STICKY = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [LZC_W-1:0]  in_lzc,
    input  logic              in_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_data,
    output logic              norm_err
);

    stage_t s1_in;
    stage_t s1_out;
    stage_t s2_out;
    logic   s1_valid;
    logic   s2_ready;
    logic   unused_s2;

    // A zero operand enters as an all-zero mantissa so lzc becomes irrelevant.
    always_comb begin
        s1_in      = '0;
        s1_in.mant = in_zero ? '0 : in_mant;
        s1_in.lzc  = in_lzc[AMT_W-1:0];
        s1_in.zero = in_zero;
    end

    denorm_shift_stage #(.SHIFT_LOG2(2), .FINAL(1'b0)) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .in_amt    (in_lzc[LZC_W-1:AMT_W]),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_out)
    );

    denorm_shift_stage #(.SHIFT_LOG2(0), .FINAL(1'b1)) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s1_out),
        .in_amt    (s1_out.lzc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_out)
    );

    assign out_data  = s2_out.mant;
    assign unused_s2 = ^{s2_out.lzc, s2_out.zero, s2_out.rnd};

    // Malformed mantissa flag, judged on the accepted input itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            norm_err <= 1'b0;
        end else if (in_valid && in_ready && !in_zero && !in_mant[MANT_W-1]) begin
            norm_err <= 1'b1;
        end else if (!ERR_STICKY) begin
            norm_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_denorm_16bit.sv
// Scoreboard bench for denorm_16bit; expectations come from a behavioural shift model.
module tb_denorm_16bit;

    localparam bit STICKY = 1'b1;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_mant;
    logic [3:0]  in_lzc;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        norm_err;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_lat = 0;
    int   tcnt = 0;
    bit   toggle_en = 1'b0;
    bit   rand_en = 1'b0;
    bit   saw_full = 1'b0;
    logic exp_err = 1'b0;

    denorm_16bit #(.ERR_STICKY(STICKY)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_lzc    (in_lzc),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .norm_err  (norm_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [15:0] m, input logic [3:0] l, input logic z);
        logic [15:0] r;
        if (z) return 16'h0000;
        r = m >> l;
`ifdef DENORM_ROUND_EN
        if (l != 4'd0) r = r + 16'(m[l - 4'd1]);
`endif
        return r;
    endfunction

    // One clock: check at the falling edge, update the model, return after the rising edge.
    task automatic step(output bit acc);
        logic exp_rdy;
        exp_t e;
        @(negedge clk);
        cyc++;
        acc = 1'b0;
        exp_rdy = (sb.size() < 2) || out_ready;
        n_vec++;
        assert (in_ready === exp_rdy) else begin
            n_err++;
            $error("FAIL in_ready observed=%b expected=%b cyc=%0d", in_ready, exp_rdy, cyc);
        end
        if (in_ready === 1'b0) saw_full = 1'b1;
        n_vec++;
        assert (norm_err === exp_err) else begin
            n_err++;
            $error("FAIL norm_err observed=%b expected=%b cyc=%0d", norm_err, exp_err, cyc);
        end
        if (out_valid === 1'b1 && out_ready) begin
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL spurious_out observed=%h expected=none cyc=%0d", out_data, cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                last_lat = cyc - e.cyc;
                n_vec++;
                assert (out_data === e.data) else begin
                    n_err++;
                    $error("FAIL out_data observed=%h expected=%h cyc=%0d", out_data, e.data, cyc);
                end
            end
        end
        if (in_valid && in_ready) begin
            acc = 1'b1;
            sb.push_back('{data: model(in_mant, in_lzc, in_zero), cyc: cyc});
        end
        if (STICKY) exp_err = exp_err | (acc && !in_zero && !in_mant[15]);
        else        exp_err = acc && !in_zero && !in_mant[15];
        @(posedge clk);
        #1;
        if (toggle_en) begin
            tcnt++;
            out_ready = (tcnt % 4 == 0) || (tcnt % 4 == 3);
        end else if (rand_en) begin
            out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic tick();
        bit a;
        step(a);
    endtask

    task automatic send(input logic [15:0] m, input logic [3:0] l, input logic z);
        bit a;
        in_valid = 1'b1;
        in_mant  = m;
        in_lzc   = l;
        in_zero  = z;
        a = 1'b0;
        for (int i = 0; i < 40 && !a; i++) step(a);
        in_valid = 1'b0;
        n_vec++;
        assert (a) else begin
            n_err++;
            $error("FAIL accept_timeout observed=%b expected=1 mant=%h", a, m);
        end
    endtask

    task automatic drain();
        toggle_en = 1'b0;
        rand_en   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        n_vec++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL drain observed=%0d pending expected=0", sb.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mant   = '0;
        in_lzc    = '0;
        in_zero   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #12;
        n_vec++;
        assert (out_valid === 1'b0) else begin n_err++; $error("FAIL rst_valid observed=%b expected=0", out_valid); end
        n_vec++;
        assert (out_data === 16'h0000) else begin n_err++; $error("FAIL rst_data observed=%h expected=0000", out_data); end
        n_vec++;
        assert (norm_err === 1'b0) else begin n_err++; $error("FAIL rst_err observed=%b expected=0", norm_err); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single transaction, latency 2
        send(16'hA000, 4'd5, 1'b0);
        drain();
        n_vec++;
        assert (last_lat == 2) else begin n_err++; $error("FAIL latency observed=%0d expected=2", last_lat); end

        // Extreme shift
        send(16'hFFFF, 4'd15, 1'b0);
        send(16'h8000, 4'd15, 1'b0);
        send(16'hC001, 4'd0, 1'b0);
        drain();

        // Back-to-back with out_ready 1,0,0,1,...
        toggle_en = 1'b1;
        tcnt      = 0;
        out_ready = 1'b1;
        saw_full  = 1'b0;
        for (int k = 0; k < 4; k++) send(16'h8000, 4'(k), 1'b0);
        drain();
        n_vec++;
        assert (saw_full) else begin n_err++; $error("FAIL backpressure observed=%b expected=1", saw_full); end

        // Random traffic under random out_ready
        rand_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            send(16'h8000 | 16'($urandom_range(0, 16'h7FFF)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 7) == 0));
        end
        drain();

        // Zero operand ignores lzc; malformed mantissa raises norm_err
        send(16'h1234, 4'd7, 1'b1);
        drain();
        n_vec++;
        assert (norm_err === 1'b0) else begin n_err++; $error("FAIL zero_err observed=%b expected=0", norm_err); end
        send(16'h1234, 4'd3, 1'b0);
        drain();
        repeat (3) tick();
        n_vec++;
        assert (norm_err === STICKY) else begin n_err++; $error("FAIL err_hold observed=%b expected=%b", norm_err, STICKY); end

        // Reset with two transactions in flight
        out_ready = 1'b0;
        send(16'h8000, 4'd0, 1'b0);
        send(16'h8000, 4'd1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        assert (out_valid === 1'b0) else begin n_err++; $error("FAIL midrst_valid observed=%b expected=0", out_valid); end
        n_vec++;
        assert (out_data === 16'h0000) else begin n_err++; $error("FAIL midrst_data observed=%h expected=0000", out_data); end
        n_vec++;
        assert (norm_err === 1'b0) else begin n_err++; $error("FAIL midrst_err observed=%b expected=0", norm_err); end
        sb.delete();
        exp_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) tick();
        n_vec++;
        assert (out_valid === 1'b0) else begin n_err++; $error("FAIL stale_out observed=%b expected=0", out_valid); end

        // Recovery after reset
        send(16'hA000, 4'd5, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
